// File: rtl/sha_krom_stream.sv
// sha_krom_stream
//   Streaming read port onto a constant ROM (the 64 SHA-256 round
//   constants). A request is either a single-word read or a burst of up to
//   ROM_DEPTH consecutive words. Addresses wrap at the top of the ROM. Read
//   data passes through a READ_LATENCY-deep pipeline and then into an output
//   FIFO of READ_LATENCY+1 entries. Reads are only issued while an output
//   credit is free, so a stalled consumer never causes a word to be dropped.
//
// Parameters
//   DATA_WIDTH   ROM word width
//   ADDR_WIDTH   address width, ROM_DEPTH = 2**ADDR_WIDTH
//   READ_LATENCY cycles from request accept to first dvalid0 (1..4)
//   INIT_FILE    name of the content image; the ROM holds the built-in
//                SHA-256 K table
//
// Ports
//   clk0        clock, all state changes on its rising edge
//   rst0        synchronous active-high reset
//   cs0         request valid
//   addr0       request start address
//   burst0      1 = burst of len0+1 words, 0 = single word
//   len0        burst length minus one
//   req_ready0  request is accepted this cycle if cs0 is high
//   dout0       read data (zero when dvalid0 is low)
//   dvalid0     dout0 holds a valid word
//   dready0     consumer takes dout0
//   dlast0      dout0 is the final word of its request
//   busy0       a request is issuing, or words are in flight or buffered
module sha_krom_stream #(
  parameter int    DATA_WIDTH   = 32,
  parameter int    ADDR_WIDTH   = 6,
  parameter int    READ_LATENCY = 2,
  parameter string INIT_FILE    = "rom_configs/k.bin"
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  cs0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic                  burst0,
  input  logic [ADDR_WIDTH-1:0] len0,
  output logic                  req_ready0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  dvalid0,
  input  logic                  dready0,
  output logic                  dlast0,
  output logic                  busy0
);

  localparam int ROM_DEPTH = 2 ** ADDR_WIDTH;
  localparam int CREDITS   = READ_LATENCY + 1;
  localparam int CW        = $clog2(CREDITS + 1);
  localparam int PW        = $clog2(CREDITS);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH-1:0] rem_cnt;
  logic [CW-1:0]         credits;
  logic                  have_credit;
  logic                  issue;
  logic                  issue_last;
  logic                  burst_start;
  logic [ADDR_WIDTH-1:0] issue_addr;
  logic                  xfer;
  logic [DATA_WIDTH-1:0] rom_rd;

  logic                  fin_vld;
  logic                  fin_last;
  logic [DATA_WIDTH-1:0] fin_data;

  logic [DATA_WIDTH-1:0] fifo_data [CREDITS];
  logic                  fifo_last [CREDITS];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         fifo_cnt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(CREDITS - 1)) ? '0 : p + 1'b1;
  endfunction

  assign have_credit = (credits != '0);
  assign xfer        = dvalid0 && dready0;

  // FSM: state register
  always_ff @(posedge clk0) begin
    if (rst0) state <= IDLE;
    else      state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (burst_start) state_nxt = BURST;
      BURST:   if (issue && issue_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs. In IDLE the accepted request issues its first word in the
  // accept cycle; BURST issues the remaining words one per free credit.
  always_comb begin
    req_ready0  = 1'b0;
    issue       = 1'b0;
    issue_last  = 1'b0;
    burst_start = 1'b0;
    issue_addr  = cur_addr;
    case (state)
      IDLE: begin
        req_ready0 = !rst0 && have_credit;
        if (cs0 && req_ready0) begin
          issue       = 1'b1;
          issue_addr  = addr0;
          burst_start = burst0 && (len0 != '0);
          issue_last  = !burst_start;
        end
      end
      BURST: begin
        issue      = have_credit;
        issue_addr = cur_addr;
        issue_last = (rem_cnt == ADDR_WIDTH'(1));
      end
      default: ;
    endcase
  end

  // rem_cnt counts words still to issue while in BURST; the address wraps
  // naturally at ADDR_WIDTH bits.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      cur_addr <= '0;
      rem_cnt  <= '0;
    end else if (burst_start) begin
      cur_addr <= addr0 + 1'b1;
      rem_cnt  <= len0;
    end else if (state == BURST && issue) begin
      cur_addr <= cur_addr + 1'b1;
      rem_cnt  <= rem_cnt - 1'b1;
    end
  end

  // One credit per output FIFO slot; an issue and a transfer in the same
  // cycle cancel out.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      credits <= CW'(CREDITS);
    end else begin
      case ({issue, xfer})
        2'b10:   credits <= credits - 1'b1;
        2'b01:   credits <= credits + 1'b1;
        default: credits <= credits;
      endcase
    end
  end

  // ROM array
  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  logic [5:0] k_idx;
  assign k_idx  = 6'(issue_addr);
  assign rom_rd = DATA_WIDTH'(K_TAB[k_idx]);

  // Read pipeline: READ_LATENCY-1 register stages between the ROM read and
  // the FIFO write; the FIFO write itself supplies the final cycle.
  if (READ_LATENCY == 1) begin : g_lat1
    assign fin_vld  = issue;
    assign fin_last = issue_last;
    assign fin_data = rom_rd;
  end else begin : g_latn
    localparam int NS = READ_LATENCY - 1;
    logic                  vld_p  [NS];
    logic                  last_p [NS];
    logic [DATA_WIDTH-1:0] data_p [NS];

    always_ff @(posedge clk0) begin
      if (rst0) begin
        for (int k = 0; k < NS; k++) vld_p[k] <= 1'b0;
      end else begin
        vld_p[0] <= issue;
        for (int k = 1; k < NS; k++) vld_p[k] <= vld_p[k-1];
      end
    end

    always_ff @(posedge clk0) begin
      last_p[0] <= issue_last;
      data_p[0] <= rom_rd;
      for (int k = 1; k < NS; k++) begin
        last_p[k] <= last_p[k-1];
        data_p[k] <= data_p[k-1];
      end
    end

    assign fin_vld  = vld_p[NS-1];
    assign fin_last = last_p[NS-1];
    assign fin_data = data_p[NS-1];
  end

  // Output FIFO: credits guarantee a free slot for every arriving word.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fin_vld) wr_ptr <= ptr_inc(wr_ptr);
      if (xfer)    rd_ptr <= ptr_inc(rd_ptr);
      case ({fin_vld, xfer})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk0) begin
    if (fin_vld) begin
      fifo_data[wr_ptr] <= fin_data;
      fifo_last[wr_ptr] <= fin_last;
    end
  end

  // Outputs are forced low while reset is asserted; dout0 is zeroed
  // whenever no word is presented.
  assign dvalid0 = !rst0 && (fifo_cnt != '0);
  assign dout0   = dvalid0 ? fifo_data[rd_ptr] : '0;
  assign dlast0  = dvalid0 && fifo_last[rd_ptr];
  assign busy0   = !rst0 && ((state == BURST) || (credits != CW'(CREDITS)) || issue);

endmodule

// File: tb/tb_sha_krom_stream.sv
module tb_sha_krom_stream;

  localparam logic [31:0] KTAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic        clk;
  logic        rst0, cs0, burst0, dready0;
  logic [5:0]  addr0, len0;
  logic        req_ready0, dvalid0, dlast0, busy0;
  logic [31:0] dout0;

  int n_assert = 0;
  int n_fail   = 0;
  int n_xfer   = 0;

  logic [31:0] exp_d [$];
  bit          exp_l [$];
  bit          stalled = 0;
  logic [31:0] held_d;
  logic        held_l;

  sha_krom_stream #(
    .DATA_WIDTH(32), .ADDR_WIDTH(6), .READ_LATENCY(2), .INIT_FILE("")
  ) dut (
    .clk0(clk), .rst0(rst0), .cs0(cs0), .addr0(addr0), .burst0(burst0),
    .len0(len0), .req_ready0(req_ready0), .dout0(dout0), .dvalid0(dvalid0),
    .dready0(dready0), .dlast0(dlast0), .busy0(busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: every accepted request appends its words to a queue;
  // each presented word must equal the queue head.
  always @(negedge clk) begin
    if (rst0) begin
      check("reset_outputs", {dvalid0, dlast0, busy0, req_ready0, dout0}, 64'd0);
      exp_d.delete();
      exp_l.delete();
      stalled = 0;
    end else begin
      if (!dvalid0) check("idle_dout_zero", {dlast0, dout0}, 64'd0);
      if (stalled) check("stall_hold", {dvalid0, dlast0, dout0}, {1'b1, held_l, held_d});
      if (dvalid0) begin
        if (exp_d.size() == 0) begin
          n_assert++;
          n_fail++;
          $display("FAIL unexpected_word: got 0x%0h, required no word (t=%0t)", dout0, $time);
        end else begin
          check("stream_word", {dlast0, dout0}, {exp_l[0], exp_d[0]});
          if (dready0) begin
            void'(exp_d.pop_front());
            void'(exp_l.pop_front());
            n_xfer++;
          end
        end
      end
      stalled = dvalid0 && !dready0;
      held_d  = dout0;
      held_l  = dlast0;
      if (cs0 && req_ready0) begin
        int n;
        n = burst0 ? int'(len0) + 1 : 1;
        for (int i = 0; i < n; i++) begin
          exp_d.push_back(KTAB[(int'(addr0) + i) % 64]);
          exp_l.push_back(i == n - 1);
        end
      end
    end
  end

  task automatic req(input logic [5:0] a, input logic b, input logic [5:0] l);
    bit got = 0;
    cs0 = 1'b1; addr0 = a; burst0 = b; len0 = l;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      got = req_ready0;
    end
    check("req_accepted", got, 1);
    @(posedge clk); #1;
    cs0 = 1'b0;
  endtask

  task automatic drain(input string nm);
    bit ok = 0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clk);
      ok = !busy0 && !dvalid0 && (exp_d.size() == 0);
    end
    check(nm, ok, 1);
    @(posedge clk); #1;
  endtask

  // Latency / wrap sweep at READ_LATENCY 1 and 4 with random dready.
  for (genvar g = 0; g < 2; g++) begin : g_sweep
    localparam int LAT = (g == 0) ? 1 : 4;
    logic        s_rst, s_cs, s_burst, s_rdy, s_rr, s_dv, s_dl, s_busy;
    logic [5:0]  s_addr, s_len;
    logic [31:0] s_dout;
    int          idx = 0;
    bit          done = 0;

    sha_krom_stream #(
      .DATA_WIDTH(32), .ADDR_WIDTH(6), .READ_LATENCY(LAT), .INIT_FILE("")
    ) u_sw (
      .clk0(clk), .rst0(s_rst), .cs0(s_cs), .addr0(s_addr), .burst0(s_burst),
      .len0(s_len), .req_ready0(s_rr), .dout0(s_dout), .dvalid0(s_dv),
      .dready0(s_rdy), .dlast0(s_dl), .busy0(s_busy)
    );

    always @(negedge clk) begin
      if (!s_rst) begin
        if (!s_dv) check("sweep_idle_zero", {s_dl, s_dout}, 64'd0);
        if (s_dv && s_rdy) begin
          check("sweep_word", {s_dl, s_dout}, {idx == 63, KTAB[(60 + idx) % 64]});
          idx++;
        end
      end
    end

    initial begin
      int lat = 0;
      bit got = 0;
      s_rst = 1'b1; s_cs = 1'b0; s_addr = '0; s_burst = 1'b0; s_len = '0; s_rdy = 1'b0;
      repeat (3) @(posedge clk);
      #1 s_rst = 1'b0;
      s_cs = 1'b1; s_addr = 6'd60; s_burst = 1'b1; s_len = 6'd63;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge clk);
        got = s_rr;
      end
      check("sweep_accept", got, 1);
      @(posedge clk); #1;
      s_cs = 1'b0;
      got = 0;
      for (int k = 1; k <= 12 && !got; k++) begin
        @(negedge clk);
        if (s_dv) begin
          got = 1;
          lat = k;
        end
      end
      check("sweep_latency", lat, LAT);
      for (int k = 0; k < 2000 && idx < 64; k++) begin
        @(posedge clk); #1;
        s_rdy = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      s_rdy = 1'b1;
      repeat (LAT + 3) @(posedge clk);
      @(negedge clk);
      check("sweep_count", idx, 64);
      check("sweep_idle", {s_busy, s_dv}, 0);
      done = 1;
    end
  end

  initial begin
    int gap;
    bit got;
    rst0 = 1'b1; cs0 = 1'b0; addr0 = '0; burst0 = 1'b0; len0 = '0; dready0 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready0, 0);
    @(posedge clk); #1;
    rst0 = 1'b0;
    @(negedge clk);
    check("post_rst_ready", req_ready0, 1);
    check("post_rst_busy", busy0, 0);
    @(posedge clk); #1;

    // Single read, address 0: word after two cycles.
    req(6'd0, 1'b0, 6'd0);
    @(negedge clk);
    check("single_lat_c1", dvalid0, 0);
    @(negedge clk);
    check("single_c2", {dvalid0, dlast0, dout0}, {1'b1, 1'b1, 32'h428a2f98});
    @(posedge clk); #1;
    drain("drain_single");

    // Wrapping burst 62..1.
    req(6'd62, 1'b1, 6'd3);
    @(negedge clk);
    check("burst_ready_low", req_ready0, 0);
    check("burst_busy", busy0, 1);
    check("burst_lat_c1", dvalid0, 0);
    begin
      logic [31:0] wrap_exp [4];
      wrap_exp = '{32'hbef9a3f7, 32'hc67178f2, 32'h428a2f98, 32'h71374491};
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        check("wrap_word", {dvalid0, dlast0, dout0}, {1'b1, i == 3, wrap_exp[i]});
      end
    end
    @(posedge clk); #1;
    drain("drain_wrap");

    // cs0 held through a burst with another address: accepted only when idle.
    cs0 = 1'b1; addr0 = 6'd10; burst0 = 1'b1; len0 = 6'd7;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = req_ready0;
    end
    check("b2b_first_accept", got, 1);
    @(posedge clk); #1;
    addr0 = 6'd40; burst0 = 1'b0;
    gap = -1;
    for (int k = 1; k <= 30 && gap < 0; k++) begin
      @(negedge clk);
      if (req_ready0) gap = k;
    end
    check("b2b_gap", gap, 8);
    @(posedge clk); #1;
    cs0 = 1'b0;
    drain("drain_b2b");

    // One-word burst and a stalled single read.
    req(6'd63, 1'b1, 6'd0);
    drain("drain_burst1");
    dready0 = 1'b0;
    req(6'd5, 1'b0, 6'd0);
    repeat (6) @(posedge clk);
    #1 dready0 = 1'b1;
    drain("drain_stall_single");

    // Full table with a 10-cycle consumer stall mid-stream.
    req(6'd0, 1'b1, 6'd63);
    repeat (15) @(posedge clk);
    #1 dready0 = 1'b0;
    repeat (10) @(posedge clk);
    #1 dready0 = 1'b1;
    drain("drain_full_stall");

    // Random consumer back-pressure on a wrapping burst.
    req(6'd50, 1'b1, 6'd20);
    for (int k = 0; k < 300 && (busy0 || dvalid0 || exp_d.size() != 0); k++) begin
      dready0 = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    dready0 = 1'b1;
    drain("drain_rand");

    // Reset in the middle of a full burst.
    begin
      int base;
      base = n_xfer;
      req(6'd0, 1'b1, 6'd63);
      got = 0;
      for (int k = 0; k < 100 && !got; k++) begin
        @(negedge clk);
        got = (n_xfer >= base + 5);
      end
      check("abort_reached_word5", got, 1);
    end
    @(posedge clk); #1;
    rst0 = 1'b1;
    @(posedge clk); #1;
    rst0 = 1'b0;
    @(negedge clk);
    check("abort_after", {dvalid0, busy0, req_ready0}, 3'b001);
    @(posedge clk); #1;
    req(6'd1, 1'b0, 6'd0);
    @(negedge clk);
    check("abort_read_c1", dvalid0, 0);
    @(negedge clk);
    check("abort_read_c2", {dvalid0, dlast0, dout0}, {1'b1, 1'b1, 32'h71374491});
    @(posedge clk); #1;
    drain("drain_abort");

    got = 0;
    for (int k = 0; k < 5000 && !got; k++) begin
      @(posedge clk);
      got = g_sweep[0].done && g_sweep[1].done;
    end
    check("sweep_done", got, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
